// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_t      : FSM state encoding (TAG_LOAD only reachable with UART_TX_ARB_TAG_EN)
//   clog2()          : index width helper, never returns less than 1
//   TAG_BASE_DEFAULT : default base value for source tag bytes
//   TMO_W            : width of the start-timeout counter
package uart_arb_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD       = 3'd1,
      WAIT_START = 3'd2,
      WAIT_DONE  = 3'd3,
      TAG_LOAD   = 3'd4
   } arb_state_t;

   localparam logic [7:0] TAG_BASE_DEFAULT = 8'hF0;
   localparam int         TMO_W            = 5;

   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
//   valid     : request vector
//   ptr       : index of the last winner; search starts at ptr+1 and wraps
//   grant     : one-hot winner (all zero when nothing is valid)
//   idx       : binary index of the winner
//   any_valid : at least one request is valid
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    idx,
   output logic               any_valid
);

   // Outer loop walks the priority order ptr+1, ptr+2, ... ; the first
   // valid requester met in that order wins.
   always_comb begin
      grant     = '0;
      idx       = '0;
      any_valid = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && valid[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
               any_valid = 1'b1;
               grant[i]  = 1'b1;
               idx       = ID_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// producers, one byte per grant.
//   clk, rst             : clock and synchronous active-high reset
//   req_valid/req_data   : per-requester byte offer (requester i on bits [8i+7:8i])
//   req_ready            : one-cycle accept, at most one bit high
//   uart_transmit        : one-cycle transmit pulse to the UART
//   uart_tx_byte         : byte to the UART, stable until the byte completes
//   uart_is_transmitting : UART busy flag
//   grant_id             : index of the last accepted requester
//   busy                 : FSM not in IDLE
// Optional macro UART_TX_ARB_TAG_EN: precede a byte with tag TAG_BASE+g
// whenever the source changes (and on the first grant after reset).
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int         NUM_REQ       = 4,
   parameter int         START_TIMEOUT = 16,
   parameter logic [7:0] TAG_BASE      = TAG_BASE_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*8-1:0]        req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        uart_transmit,
   output logic [7:0]                  uart_tx_byte,
   input  logic                        uart_is_transmitting,
   output logic [clog2(NUM_REQ)-1:0]   grant_id,
   output logic                        busy
);

   localparam int               ID_W     = clog2(NUM_REQ);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

   arb_state_t          state, state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [NUM_REQ-1:0]  pick_grant;
   logic [ID_W-1:0]     pick_idx;
   logic                pick_any;
   logic                take;
   logic [7:0]          sel_byte;
   logic [TMO_W-1:0]    tmo_cnt;
   logic                tag_phase;
   logic                need_tag;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .valid     (req_valid),
      .ptr       (rr_ptr),
      .grant     (pick_grant),
      .idx       (pick_idx),
      .any_valid (pick_any)
   );

   always_comb begin
      sel_byte = 8'h00;
      for (int i = 0; i < NUM_REQ; i++)
         if (pick_grant[i]) sel_byte = req_data[8*i +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Ready is gated by rst so no handshake can complete in a reset cycle.
   always_comb begin
      state_nxt     = state;
      take          = 1'b0;
      uart_transmit = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any && !uart_is_transmitting && !rst) begin
               take      = 1'b1;
               state_nxt = need_tag ? TAG_LOAD : LOAD;
            end
         end
         LOAD, TAG_LOAD: begin
            uart_transmit = 1'b1;
            state_nxt     = WAIT_START;
         end
         WAIT_START: begin
            if (uart_is_transmitting)  state_nxt = WAIT_DONE;
            else if (tmo_cnt == TMO_LAST) state_nxt = tag_phase ? TAG_LOAD : LOAD;
         end
         WAIT_DONE: begin
            if (!uart_is_transmitting) state_nxt = tag_phase ? LOAD : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign req_ready = take ? pick_grant : '0;
   assign busy      = (state != IDLE);

`ifdef UART_TX_ARB_TAG_EN
   logic            src_seen;
   logic [ID_W-1:0] last_src;
   logic [7:0]      data_hold;

   assign need_tag = !src_seen || (pick_idx != last_src);

   // tag_phase marks that the byte in flight is a tag and the held data
   // byte still has to follow without re-arbitration.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_phase <= 1'b0;
         src_seen  <= 1'b0;
         last_src  <= '0;
      end else if (take) begin
         tag_phase <= need_tag;
         src_seen  <= 1'b1;
         last_src  <= pick_idx;
      end else if (state == WAIT_DONE && !uart_is_transmitting) begin
         tag_phase <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (take) data_hold <= sel_byte;
   end
`else
   logic unused_tag_base;
   assign tag_phase       = 1'b0;
   assign need_tag        = 1'b0;
   assign unused_tag_base = ^TAG_BASE;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         uart_tx_byte <= 8'h00;
         grant_id     <= '0;
         rr_ptr       <= ID_W'(NUM_REQ - 1);
         tmo_cnt      <= '0;
      end else begin
         if (take) begin
            grant_id <= pick_idx;
            rr_ptr   <= pick_idx;
`ifdef UART_TX_ARB_TAG_EN
            uart_tx_byte <= need_tag ? (TAG_BASE + 8'(pick_idx)) : sel_byte;
         end else if (tag_phase && state == WAIT_DONE && !uart_is_transmitting) begin
            uart_tx_byte <= data_hold;
`else
            uart_tx_byte <= sel_byte;
`endif
         end
         // Counter restarts on every pulse, so a re-pulse gets a full window.
         if (uart_transmit)            tmo_cnt <= '0;
         else if (state == WAIT_START) tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural UART model.
module tb_uart_tx_arbiter;

   localparam int NR = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [NR-1:0]   req_valid;
   logic [NR*8-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            uart_transmit;
   logic [7:0]      uart_tx_byte;
   logic            uart_is_transmitting;
   logic [1:0]      grant_id;
   logic            busy;

   int checks = 0;
   int errors = 0;

   // UART model: goes busy the edge after a pulse, stays busy busy_len cycles.
   logic       mtx = 1'b0;
   logic       force_busy = 1'b0;
   int         busy_left = 0;
   int         busy_len = 20;
   int         pulse_cnt = 0;
   int         ignore_pulse_no = -1;
   int         cyc = 0;
   logic [7:0] tx_log[$];
   int         tx_cyc[$];

   int n, base, bad, nrdy;
   int rcnt[NR];

   assign uart_is_transmitting = mtx | force_busy;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ       (NR),
      .START_TIMEOUT (16)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_valid            (req_valid),
      .req_data             (req_data),
      .req_ready            (req_ready),
      .uart_transmit        (uart_transmit),
      .uart_tx_byte         (uart_tx_byte),
      .uart_is_transmitting (uart_is_transmitting),
      .grant_id             (grant_id),
      .busy                 (busy)
   );

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (uart_transmit) begin
         tx_log.push_back(uart_tx_byte);
         tx_cyc.push_back(cyc);
         pulse_cnt <= pulse_cnt + 1;
         if (pulse_cnt != ignore_pulse_no) begin
            mtx       <= 1'b1;
            busy_left <= busy_len - 1;
         end
      end else if (mtx) begin
         if (busy_left == 0) mtx <= 1'b0;
         else                busy_left <= busy_left - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for ready on idx, checks it is the only ready bit,
   // then drops that valid just after the accepting edge.
   task automatic wait_ready(input int idx, input string tag);
      int k;
      k = 0;
      #1;
      while (req_ready[idx] !== 1'b1 && k < 1000) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk({tag, "_ready"}, 32'(req_ready), 32'd1 << idx);
      @(posedge clk);
      #1;
      req_valid[idx] = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      @(negedge clk);
      while (busy !== 1'b0 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp2[5];
      int         expc[NR];
      logic [7:0] expt[5];
      exp2 = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
      expc = '{2, 1, 1, 1};
      expt = '{8'hF1, 8'h55, 8'h66, 8'hF3, 8'h77};

      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_transmit", 32'(uart_transmit), 32'd0);
      chk("rst_byte", 32'(uart_tx_byte), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

`ifndef UART_TX_ARB_TAG_EN
      // Single byte with a 160-cycle UART frame
      @(negedge clk);
      busy_len = 160;
      req_data[23:16] = 8'hA5;
      req_valid[2]    = 1'b1;
      #1;
      chk("t1_ready", 32'(req_ready), 32'h4);
      @(posedge clk);
      #1;
      req_valid[2] = 1'b0;
      @(negedge clk);
      chk("t1_pulse", 32'(uart_transmit), 32'd1);
      chk("t1_byte", 32'(uart_tx_byte), 32'hA5);
      chk("t1_grant_id", 32'(grant_id), 32'd2);
      chk("t1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t1_pulse_end", 32'(uart_transmit), 32'd0);
      n = 1;
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("t1_done_cycles", n, 162);
      chk("t1_log_size", tx_log.size(), 1);
      chk("t1_log_byte", 32'(tx_log[0]), 32'hA5);

      // All four continuously valid: round robin from requester 0
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst       = 1'b0;
      busy_len  = 10;
      base      = tx_log.size();
      req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
      req_valid = '1;
      nrdy      = 0;
      n         = 0;
      for (int i = 0; i < NR; i++) rcnt[i] = 0;
      while (nrdy < 5 && n < 500) begin
         #1;
         if (req_ready != '0) begin
            chk("t2_onehot", 32'($onehot(req_ready)), 32'd1);
            for (int i = 0; i < NR; i++) if (req_ready[i]) rcnt[i]++;
            nrdy++;
            if (nrdy == 5) begin
               @(posedge clk);
               #1;
               req_valid = '0;
            end
         end
         @(negedge clk);
         n++;
      end
      wait_idle("t2");
      chk("t2_log_size", tx_log.size() - base, 5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("t2_byte%0d", i), 32'(tx_log[base + i]), 32'(exp2[i]));
      for (int i = 0; i < NR; i++)
         chk($sformatf("t2_ready_count%0d", i), rcnt[i], expc[i]);

      // UART busy out of reset: no grant until it falls
      force_busy = 1'b1;
      rst        = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst            = 1'b0;
      req_data[7:0]  = 8'h5C;
      req_valid      = 4'b0001;
      bad            = 0;
      repeat (50) begin
         #1;
         if (req_ready != '0 || uart_transmit) bad++;
         @(negedge clk);
      end
      chk("t3_no_grant", bad, 0);
      chk("t3_busy_low", 32'(busy), 32'd0);
      force_busy = 1'b0;
      #1;
      chk("t3_ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      req_valid = '0;
      @(negedge clk);
      chk("t3_pulse", 32'(uart_transmit), 32'd1);
      chk("t3_byte", 32'(uart_tx_byte), 32'h5C);
      wait_idle("t3");

      // First pulse ignored: re-pulse after the 16-cycle start window
      base            = tx_log.size();
      ignore_pulse_no = pulse_cnt;
      req_data[15:8]  = 8'h3C;
      req_valid[1]    = 1'b1;
      wait_ready(1, "t4");
      wait_idle("t4");
      ignore_pulse_no = -1;
      chk("t4_pulse_count", tx_log.size() - base, 2);
      chk("t4_byte_first", 32'(tx_log[base]), 32'h3C);
      chk("t4_byte_second", 32'(tx_log[base + 1]), 32'h3C);
      chk("t4_pulse_gap", tx_cyc[base + 1] - tx_cyc[base], 17);

      // Reset during WAIT_DONE
      busy_len        = 20;
      req_data[31:24] = 8'h99;
      req_valid[3]    = 1'b1;
      wait_ready(3, "t5");
      repeat (6) @(negedge clk);
      chk("t5_grant_id_pre", 32'(grant_id), 32'd3);
      chk("t5_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_ready", 32'(req_ready), 32'd0);
      chk("t5_rst_transmit", 32'(uart_transmit), 32'd0);
      chk("t5_rst_byte", 32'(uart_tx_byte), 32'd0);
      chk("t5_rst_grant_id", 32'(grant_id), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      rst             = 1'b0;
      base            = tx_log.size();
      req_data[7:0]   = 8'h11;
      req_data[31:24] = 8'h33;
      req_valid       = 4'b1001;
      wait_ready(0, "t5_after");
      req_valid = '0;
      wait_idle("t5");
      chk("t5_grant_id_after", 32'(grant_id), 32'd0);
      chk("t5_log_size", tx_log.size() - base, 1);
      chk("t5_byte_after", 32'(tx_log[base]), 32'h11);
`else
      // Source tags: F1,55,66,F3,77
      @(negedge clk);
      busy_len        = 10;
      base            = tx_log.size();
      req_data[15:8]  = 8'h55;
      req_valid[1]    = 1'b1;
      wait_ready(1, "tag55");
      req_data[15:8]  = 8'h66;
      req_valid[1]    = 1'b1;
      wait_ready(1, "tag66");
      req_data[31:24] = 8'h77;
      req_valid[3]    = 1'b1;
      wait_ready(3, "tag77");
      wait_idle("tag");
      chk("tag_log_size", tx_log.size() - base, 5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("tag_byte%0d", i), 32'(tx_log[base + i]), 32'(expt[i]));
      chk("tag_grant_id", 32'(grant_id), 32'd3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
